// File: rtl/corner_tracker.sv
// corner_tracker: tracks the four extreme marker hits per frame and starts the transform once they settle.
module corner_tracker #(
  parameter int MIN_HITS      = 16,
  parameter int TOL           = 2,
  parameter int STABLE_FRAMES = 3,
  parameter int DONE_MASK     = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pix_valid,
  input  logic       pix_hit,
  input  logic [9:0] pix_x,
  input  logic [8:0] pix_y,
  input  logic       frame_end,
  input  logic       transform_done,
  output logic [9:0] x1_out,
  output logic [9:0] x2_out,
  output logic [9:0] x3_out,
  output logic [9:0] x4_out,
  output logic [8:0] y1_out,
  output logic [8:0] y2_out,
  output logic [8:0] y3_out,
  output logic [8:0] y4_out,
  output logic       corners_valid,
  output logic       transform_start,
  output logic       busy
);
  localparam int MW = $clog2(DONE_MASK + 2);
  localparam logic [18:0] MIN_H = 19'(MIN_HITS);
  localparam logic [7:0] SF = 8'(STABLE_FRAMES);
  localparam logic [MW-1:0] MASK = MW'(DONE_MASK);
  typedef enum logic {TRACK, BUSY} state_t;
  state_t state, state_nxt;
  // Corner slots: 0 = TL, 1 = BL, 2 = BR, 3 = TR
  logic [3:0][9:0] cx, cx_nxt, px, ox;
  logic [3:0][8:0] cy, cy_nxt, py, oy;
  logic [18:0] hit_cnt, hit_nxt;
  logic [7:0] stable_cnt, sc_nxt;
  logic [MW-1:0] mask;
  logic [3:0] take;
  logic partial, hit, first, stable, valid_frame, release_ok, go;
  function automatic logic [10:0] sum(input logic [9:0] x, input logic [8:0] y);
    return {1'b0, x} + {2'b0, y};
  endfunction
  function automatic logic signed [10:0] dif(input logic [9:0] x, input logic [8:0] y);
    return signed'({1'b0, x} - {2'b0, y});
  endfunction
  function automatic logic near(input logic [9:0] a, input logic [9:0] b);
    return (a > b ? a - b : b - a) <= 10'(TOL);
  endfunction
  assign hit = pix_valid && pix_hit;
  assign first = hit_cnt == '0;
  assign hit_nxt = (hit && hit_cnt != '1) ? hit_cnt + 19'd1 : hit_cnt;
  // Strict compares keep the earliest hit in raster order on ties
  assign take[0] = first || sum(pix_x, pix_y) < sum(cx[0], cy[0]);
  assign take[1] = first || dif(pix_x, pix_y) < dif(cx[1], cy[1]);
  assign take[2] = first || sum(pix_x, pix_y) > sum(cx[2], cy[2]);
  assign take[3] = first || dif(pix_x, pix_y) > dif(cx[3], cy[3]);
  always_comb begin
    cx_nxt = cx;
    cy_nxt = cy;
    stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (hit && take[i]) begin
        cx_nxt[i] = pix_x;
        cy_nxt[i] = pix_y;
      end
      stable &= near(cx_nxt[i], px[i]) && near({1'b0, cy_nxt[i]}, {1'b0, py[i]});
    end
  end
  assign valid_frame = frame_end && !partial && hit_nxt >= MIN_H;
  assign sc_nxt = !frame_end ? stable_cnt :
                  !valid_frame ? 8'd0 :
                  (stable_cnt != '0 && stable) ? (stable_cnt == '1 ? stable_cnt : stable_cnt + 8'd1) : 8'd1;
  assign release_ok = state == BUSY && mask == '0 && transform_done;
  assign go = valid_frame && sc_nxt >= SF && (state == TRACK || release_ok);
  always_comb begin
    state_nxt = state;
    state_nxt = go ? BUSY : release_ok ? TRACK : state;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= TRACK;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cx <= '0;
      cy <= '0;
      px <= '0;
      py <= '0;
      ox <= '0;
      oy <= '0;
      hit_cnt <= '0;
      stable_cnt <= '0;
      mask <= '0;
      partial <= 1'b1;
      corners_valid <= 1'b0;
      transform_start <= 1'b0;
    end else begin
      hit_cnt <= frame_end ? '0 : hit_nxt;
      cx <= frame_end ? '0 : cx_nxt;
      cy <= frame_end ? '0 : cy_nxt;
      if (frame_end) partial <= 1'b0;
      if (valid_frame) begin
        px <= cx_nxt;
        py <= cy_nxt;
      end
      stable_cnt <= go ? '0 : sc_nxt;
      transform_start <= go;
      if (go) begin
        ox <= cx_nxt;
        oy <= cy_nxt;
        corners_valid <= 1'b1;
        mask <= MASK;
      end else if (mask != '0) mask <= mask - 1'b1;
    end
  end
  assign busy = state == BUSY;
  assign {x1_out, x2_out, x3_out, x4_out} = {ox[0], ox[1], ox[2], ox[3]};
  assign {y1_out, y2_out, y3_out, y4_out} = {oy[0], oy[1], oy[2], oy[3]};
endmodule

// File: tb/tb_corner_tracker.sv
// tb_corner_tracker: directed and random frames checked against a frame-level reference model.
module tb_corner_tracker;
  localparam int MIN_HITS = 4, TOL = 2, SF = 2, DM = 8;
  logic clk = 1'b0, reset_n, pix_valid, pix_hit, frame_end, transform_done;
  logic [9:0] pix_x, x1_out, x2_out, x3_out, x4_out;
  logic [8:0] pix_y, y1_out, y2_out, y3_out, y4_out;
  logic corners_valid, transform_start, busy;
  int total = 0, bad = 0, n;
  int hx[$], hy[$], fx[$], fy[$];
  int mcx[4], mcy[4], prev_x[4], prev_y[4], ex[4], ey[4];
  int sc, since;
  bit partial_m, busy_m, start_m, cv_m;

  corner_tracker #(.MIN_HITS(MIN_HITS), .TOL(TOL), .STABLE_FRAMES(SF), .DONE_MASK(DM)) dut (
    .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid), .pix_hit(pix_hit), .pix_x(pix_x),
    .pix_y(pix_y), .frame_end(frame_end), .transform_done(transform_done),
    .x1_out(x1_out), .x2_out(x2_out), .x3_out(x3_out), .x4_out(x4_out),
    .y1_out(y1_out), .y2_out(y2_out), .y3_out(y3_out), .y4_out(y4_out),
    .corners_valid(corners_valid), .transform_start(transform_start), .busy(busy));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [78:0] got, input logic [78:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [78:0] act_vec();
    return {x1_out, x2_out, x3_out, x4_out, y1_out, y2_out, y3_out, y4_out,
            corners_valid, transform_start, busy};
  endfunction

  function automatic logic [78:0] exp_vec();
    return {10'(ex[0]), 10'(ex[1]), 10'(ex[2]), 10'(ex[3]),
            9'(ey[0]), 9'(ey[1]), 9'(ey[2]), 9'(ey[3]), cv_m, start_m, busy_m};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      prev_x[i] = 0; prev_y[i] = 0; ex[i] = 0; ey[i] = 0;
    end
    sc = 0; since = 0; partial_m = 1; busy_m = 0; start_m = 0; cv_m = 0;
    hx.delete(); hy.delete();
  endtask

  // TL = min(x+y), BL = min(x-y), BR = max(x+y), TR = max(x-y); first in order wins ties
  task automatic find_corners();
    int bs[4];
    for (int k = 0; k < hx.size(); k++) begin
      int s = hx[k] + hy[k], d = hx[k] - hy[k];
      int sc4[4] = '{-s, -d, s, d};
      for (int c = 0; c < 4; c++)
        if (k == 0 || sc4[c] > bs[c]) begin
          bs[c] = sc4[c]; mcx[c] = hx[k]; mcy[c] = hy[k];
        end
    end
  endtask

  task automatic model_step(input bit h, input int x, input int y, input bit fe);
    bit rel = 0, go = 0, stable;
    if (h) begin hx.push_back(x); hy.push_back(y); end
    if (busy_m) begin
      since++;
      rel = since > DM && transform_done;
    end
    if (fe) begin
      if (partial_m) begin partial_m = 0; sc = 0; end
      else if (hx.size() < MIN_HITS) sc = 0;
      else begin
        find_corners();
        stable = 1;
        for (int i = 0; i < 4; i++)
          if ((mcx[i] > prev_x[i] ? mcx[i] - prev_x[i] : prev_x[i] - mcx[i]) > TOL ||
              (mcy[i] > prev_y[i] ? mcy[i] - prev_y[i] : prev_y[i] - mcy[i]) > TOL) stable = 0;
        sc = (sc > 0 && stable) ? sc + 1 : 1;
        prev_x = mcx; prev_y = mcy;
        go = sc >= SF && (!busy_m || rel);
      end
      hx.delete(); hy.delete();
    end
    start_m = go;
    if (go) begin
      ex = mcx; ey = mcy; cv_m = 1; sc = 0; busy_m = 1; since = 0;
    end else if (rel) busy_m = 0;
  endtask

  task automatic cyc(input bit v, input bit h, input int x, input int y, input bit fe);
    pix_valid = v; pix_hit = h; pix_x = 10'(x); pix_y = 9'(y); frame_end = fe;
    @(posedge clk);
    model_step(v && h, x, y, fe);
    #1 check("cycle", act_vec(), exp_vec());
  endtask

  task automatic send(input bit noise);
    for (int i = 0; i < fx.size(); i++) begin
      if (noise && $urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 1) == 1) cyc(1, 0, $urandom_range(0, 639), $urandom_range(0, 479), 0);
        else cyc(0, 1, $urandom_range(0, 639), $urandom_range(0, 479), 0);
      end
      cyc(1, 1, fx[i], fy[i], i == fx.size() - 1);
    end
  endtask

  task automatic set4(input int a0, b0, a1, b1, a2, b2, a3, b3);
    fx = '{a0, a1, a2, a3};
    fy = '{b0, b1, b2, b3};
  endtask

  task automatic corners_are(input string tag, input int a0, b0, a1, b1, a2, b2, a3, b3);
    check(tag, 79'({x1_out, y1_out, x2_out, y2_out, x3_out, y3_out, x4_out, y4_out}),
          79'({10'(a0), 9'(b0), 10'(a1), 9'(b1), 10'(a2), 9'(b2), 10'(a3), 9'(b3)}));
  endtask

  task automatic release_busy();
    transform_done = 1;
    for (int i = 0; i < 40 && busy === 1'b1; i++) cyc(0, 0, 0, 0, 0);
    check("release", 79'(busy), 79'(0));
    transform_done = 0;
  endtask

  initial begin
    reset_n = 0; pix_valid = 0; pix_hit = 0; pix_x = 0; pix_y = 0; frame_end = 0; transform_done = 0;
    model_reset();
    #3 check("reset", act_vec(), 79'(0));
    @(posedge clk); @(posedge clk); #1 reset_n = 1;
    // Discard, stable=1, then start one cycle after the third frame_end
    set4(100, 50, 90, 400, 600, 420, 580, 30);
    repeat (3) send(0);
    corners_are("corners_A", 100, 50, 90, 400, 600, 420, 580, 30);
    check("start_A", 79'({transform_start, busy, corners_valid}), 79'(3'b111));
    cyc(0, 0, 0, 0, 0);
    check("start_pulse", 79'(transform_start), 79'(0));
    // Moved corners while busy stay frozen
    set4(120, 70, 110, 420, 620, 440, 600, 50);
    repeat (2) send(0);
    corners_are("frozen", 100, 50, 90, 400, 600, 420, 580, 30);
    check("no_start_busy", 79'({transform_start, busy}), 79'(2'b01));
    release_busy();
    transform_done = 1;
    send(0);
    corners_are("corners_B", 120, 70, 110, 420, 620, 440, 600, 50);
    check("start_B", 79'(transform_start), 79'(1));
    n = 1;
    for (int i = 0; i < 20 && busy === 1'b1; i++) begin
      cyc(0, 0, 0, 0, 0);
      if (busy === 1'b1) n++;
    end
    check("busy_len", 79'(n), 79'(DM + 1));
    transform_done = 0;
    // Too few hits, then a 3-pixel jump restarts the count
    fx = '{100, 90, 600}; fy = '{50, 400, 420};
    send(0);
    check("few_hits", 79'(transform_start), 79'(0));
    set4(100, 50, 90, 400, 600, 420, 580, 30);
    send(0);
    set4(103, 50, 90, 400, 600, 420, 580, 30);
    send(0);
    check("jump_no_start", 79'(transform_start), 79'(0));
    send(0);
    check("jump_start", 79'(transform_start), 79'(1));
    corners_are("corners_jump", 103, 50, 90, 400, 600, 420, 580, 30);
    release_busy();
    // Ties keep the first hit; a hit on the frame_end cycle is included
    set4(20, 0, 10, 10, 300, 450, 600, 100);
    repeat (2) send(0);
    corners_are("tie", 20, 0, 300, 450, 300, 450, 600, 100);
    release_busy();
    fx.push_back(0); fy.push_back(0);
    repeat (2) send(0);
    corners_are("fe_hit", 0, 0, 300, 450, 300, 450, 600, 100);
    // Asynchronous reset in the middle of a frame while busy
    cyc(1, 1, 100, 50, 0);
    cyc(1, 1, 90, 400, 0);
    #2 reset_n = 0;
    #1 model_reset();
    check("async_reset", act_vec(), 79'(0));
    @(posedge clk); #1 reset_n = 1;
    set4(100, 50, 90, 400, 600, 420, 580, 30);
    send(0);
    check("post_reset_discard", 79'({transform_start, corners_valid}), 79'(0));
    repeat (2) send(0);
    check("post_reset_start", 79'(transform_start), 79'(1));
    // Random jittered frames with noise pixels and random done
    for (int f = 0; f < 30; f++) begin
      fx.delete(); fy.delete();
      repeat ($urandom_range(0, 3)) begin
        fx.push_back($urandom_range(200, 400)); fy.push_back($urandom_range(150, 300));
      end
      fx.push_back(100 + $urandom_range(0, 3)); fy.push_back(50 + $urandom_range(0, 3));
      fx.push_back(90 + $urandom_range(0, 3)); fy.push_back(400 + $urandom_range(0, 3));
      if ($urandom_range(0, 9) != 0) begin
        fx.push_back(600 + $urandom_range(0, 3)); fy.push_back(420 + $urandom_range(0, 3));
        fx.push_back(580 + $urandom_range(0, 3)); fy.push_back(30 + $urandom_range(0, 3));
      end
      transform_done = $urandom_range(0, 1) == 1;
      send(1);
      repeat ($urandom_range(0, 4)) cyc(0, 0, 0, 0, 0);
    end
    release_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
